com_stream_loader: RTL and testbench
====================================

Name: com_stream_loader

Overview:
- Upstream feeder for the compute array's host-load port.
- Collects a byte stream from the host link, packs bytes into 16-bit words, and buffers one full data block locally.
- Replays the block as a gap-free, one-word-per-cycle burst on com_data_in, framed by data_write_start / data_write_done.
- Needed because the consumer advances its write address every cycle once a load starts and has no back-pressure.

Parameters:
- WORDS, 1024, number of 16-bit words in one block; also the burst length.
- AW, 10, buffer address width; must satisfy 2**AW >= WORDS.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_byte  in  8  host byte.
- rx_valid  in  1  rx_byte is valid this cycle.
- rx_ready  out  1  loader accepts a byte this cycle (transfer = rx_valid & rx_ready).
- com_data_in  out  16  burst data word to the consumer.
- data_write_start  out  1  one-cycle pulse that opens the burst.
- data_write_done  out  1  one-cycle pulse coincident with the last word.
- busy  out  1  high in any state other than FILL.
- load_count  out  AW+1  number of complete words buffered in the current block.
- err  out  1  sticky error flag; cleared only by rst.

Behaviour:
- Interface fixed: single clock clk; reset rst is synchronous and active-high.
- Reset values:
  - rx_ready=1, data_write_start=0, data_write_done=0, com_data_in=0, busy=0, load_count=0, err=0.
  - state=FILL; byte phase=low.
- Reset mid-burst: aborts immediately, discards buffered data, outputs return to reset values on the next cycle.
- Packing:
  - Bytes arrive little-endian: first accepted byte -> word[7:0], second -> word[15:8].
  - The word is written to buffer[load_count] on the cycle the second byte is accepted; load_count increments on that edge.
- Buffer: WORDS x 16 synchronous-read RAM with 1-cycle read latency. Both the write and read address counters are AW bits wide.
- State FILL:
  - rx_ready=1.
  - When load_count reaches WORDS, the next state is START. rx_ready is 0 from the cycle after the final byte is accepted.
- State START (1 cycle):
  - data_write_start=1, com_data_in=0.
  - Read address is primed to 0.
- State PAD (1 cycle):
  - data_write_start=0, com_data_in=0.
  - The consumer spends this cycle on its pre-increment address slot.
- State STREAM (WORDS cycles):
  - Cycle k (k = 0..WORDS-1) drives com_data_in = buffer[k].
  - Word k therefore appears in cycle S+2+k, where S is the START cycle.
  - data_write_done=1 only in cycle S+1+WORDS, i.e. the cycle carrying word WORDS-1.
  - No bubbles are permitted.
- State DONE (1 cycle):
  - com_data_in=0, data_write_done=0.
  - load_count cleared, byte phase reset to low, then next state is FILL.
- Flow control:
  - rx_ready=0 in START, PAD, STREAM and DONE.
  - Bytes offered during these states are not accepted and are not lost; the host must hold them.
- busy=1 in START, PAD, STREAM and DONE.
- err:
  - Set if rx_valid is held continuously for more than 2*WORDS+8 cycles while rx_ready=0 (host stall timeout).
  - Otherwise set only by the optional feature.
  - err does not change state flow.
- Odd byte: a dangling low byte is retained across cycles indefinitely until its high byte arrives.

Optional Feature:
- Macro: COM_LOADER_CHECKSUM_EN.
- Defined:
  - After WORDS data words, FILL accepts one more 16-bit word: the two's-complement sum of all data words mod 2^16.
  - The loader keeps a running 16-bit sum that wraps.
  - Match -> START as normal.
  - Mismatch -> err=1, no burst is issued, buffer discarded, return to FILL after a 1-cycle DONE with data_write_done=0.
  - The checksum word is never emitted on com_data_in.
- Undefined:
  - No checksum word and no sum logic.
  - START follows immediately after word WORDS-1.

Test Plan:
- WORDS=4; send bytes 01 00 02 00 03 00 04 00 -> start pulse in cycle S; com_data_in=0 in S and S+1; 0001,0002,0003,0004 in S+2..S+5; done high only at S+5; rx_ready back to 1 at S+7.
- Host holds rx_valid with byte AA during the burst -> not accepted until FILL; after return, AA lands as the low byte of word 0 of the next block.
- rst asserted in cycle S+3 -> next cycle all outputs at reset values; next block loads from word 0 with no leftovers.
- rx_valid toggling every other cycle, WORDS=4 -> load_count steps 1..4 only on high-byte acceptance; burst is identical to scenario 1.
- With COM_LOADER_CHECKSUM_EN, WORDS=4, data as scenario 1:
  - Trailer 000A -> burst as scenario 1.
  - Trailer 000B -> err=1, no start pulse, loader back in FILL.
- Two back-to-back blocks, WORDS=1024, data = index and index+0x8000 -> each burst is exactly 1024 contiguous words; second start pulse occurs no earlier than 2048 accepted bytes after the first DONE.

Source files
------------

// File: rtl/com_stream_loader_if.sv
// com_stream_loader_if -- host-side byte stream plus burst outputs of the loader.
//
// Signals:
//   rx_byte, rx_valid       host byte and its valid strobe (driven by the host)
//   rx_ready                loader can take a byte this cycle
//   com_data_in             burst data word to the compute array
//   data_write_start/done   one-cycle burst framing pulses
//   busy                    loader is not in its fill state
//   load_count              complete words buffered in the current block (AW+1 bits)
//   err                     sticky error flag
//
// Modports: master = host / feeder side, slave = the loader itself.
interface com_stream_loader_if #(
    parameter int AW = 10
) ();
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] com_data_in;
    logic        data_write_start;
    logic        data_write_done;
    logic        busy;
    logic [AW:0] load_count;
    logic        err;

    modport master (
        output rx_byte, rx_valid,
        input  rx_ready, com_data_in, data_write_start, data_write_done,
               busy, load_count, err
    );

    modport slave (
        input  rx_byte, rx_valid,
        output rx_ready, com_data_in, data_write_start, data_write_done,
               busy, load_count, err
    );
endinterface

// File: rtl/com_stream_loader.sv
// com_stream_loader -- packs a host byte stream into 16-bit words, buffers one
// block of WORDS words, then replays it as a gap-free burst framed by
// data_write_start / data_write_done for a consumer without back-pressure.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   io    com_stream_loader_if.slave: rx_byte/rx_valid/rx_ready host handshake,
//         com_data_in, data_write_start, data_write_done, busy, load_count, err
//
// Burst timing (S = START cycle): S start pulse with data 0, S+1 pad with
// data 0, S+2..S+1+WORDS words 0..WORDS-1, done pulse on the last word,
// then one DONE cycle before returning to FILL.
//
// Optional build macro COM_LOADER_CHECKSUM_EN: FILL takes one extra trailer
// word that must equal the 16-bit wrapping sum of the data words; on mismatch
// err is set and the block is dropped without a burst.
module com_stream_loader #(
    parameter int WORDS = 1024,
    parameter int AW    = 10
) (
    input logic                clk,
    input logic                rst,
    com_stream_loader_if.slave io
);
    typedef enum logic [2:0] {FILL, START, PAD, STREAM, DONE} state_t;

    // Buffer index width; address counters stay AW wide, low bits index the RAM.
    localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int LIMIT = 2 * WORDS + 8;
    localparam int SW    = $clog2(LIMIT + 1);

    localparam logic [AW:0]   WORDS_V = (AW + 1)'(WORDS);
    localparam logic [AW:0]   LC_LAST = (AW + 1)'(WORDS - 1);
    localparam logic [AW-1:0] LAST_V  = AW'(WORDS - 1);
    localparam logic [SW-1:0] LIMIT_V = SW'(LIMIT);

    state_t        state, state_nx;

    logic [15:0]   mem [0:WORDS-1];
    logic [15:0]   rd_data;
    logic [AW:0]   load_count;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] str_cnt;
    logic          phase;       // 1: low byte held, waiting for the high byte
    logic [7:0]    lo_byte;
    logic [SW-1:0] stall_cnt;
    logic          err_q;

    logic          rx_ready;
    logic          take;
    logic          take_hi;
    logic          wr_en;
    logic [15:0]   word_in;
    logic          start_o;
    logic          done_o;
    logic [15:0]   data_o;
    logic          busy_o;

    assign take    = io.rx_valid & rx_ready;
    assign take_hi = take & phase;
    assign word_in = {io.rx_byte, lo_byte};
    // load_count == WORDS while still in FILL only happens for the checksum trailer.
    assign wr_en   = take_hi & (load_count != WORDS_V);

`ifdef COM_LOADER_CHECKSUM_EN
    logic [15:0] sum;
    logic        ck_fail;

    always_ff @(posedge clk) begin
        if (rst || state == DONE)
            sum <= '0;
        else if (wr_en)
            sum <= sum + word_in;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= FILL;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        rx_ready = 1'b0;
        start_o  = 1'b0;
        done_o   = 1'b0;
        data_o   = '0;
        busy_o   = 1'b1;
`ifdef COM_LOADER_CHECKSUM_EN
        ck_fail  = 1'b0;
`endif
        case (state)
            FILL: begin
                rx_ready = 1'b1;
                busy_o   = 1'b0;
`ifdef COM_LOADER_CHECKSUM_EN
                if (take_hi && load_count == WORDS_V) begin
                    if (word_in == sum) begin
                        state_nx = START;
                    end else begin
                        state_nx = DONE;
                        ck_fail  = 1'b1;
                    end
                end
`else
                if (wr_en && load_count == LC_LAST)
                    state_nx = START;
`endif
            end
            START: begin
                start_o  = 1'b1;
                state_nx = PAD;
            end
            PAD: begin
                state_nx = STREAM;
            end
            STREAM: begin
                data_o = rd_data;
                if (str_cnt == LAST_V) begin
                    done_o   = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = FILL;
            end
            default: begin
                state_nx = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase      <= 1'b0;
            lo_byte    <= '0;
            load_count <= '0;
            rd_addr    <= '0;
            str_cnt    <= '0;
            stall_cnt  <= '0;
            err_q      <= 1'b0;
        end else begin
            if (take) begin
                if (!phase) begin
                    lo_byte <= io.rx_byte;
                    phase   <= 1'b1;
                end else begin
                    phase <= 1'b0;
                    if (wr_en)
                        load_count <= load_count + (AW + 1)'(1);
                end
            end

            // Read address runs one ahead of the word on the bus to cover RAM latency.
            case (state)
                START: begin
                    rd_addr <= '0;
                    str_cnt <= '0;
                end
                PAD: rd_addr <= rd_addr + AW'(1);
                STREAM: begin
                    rd_addr <= rd_addr + AW'(1);
                    str_cnt <= str_cnt + AW'(1);
                end
                DONE: begin
                    load_count <= '0;
                    phase      <= 1'b0;
                end
                default: ;
            endcase

            // Host stall watchdog: valid held against a closed port too long.
            if (io.rx_valid && !rx_ready) begin
                if (stall_cnt == LIMIT_V)
                    err_q <= 1'b1;
                else
                    stall_cnt <= stall_cnt + SW'(1);
            end else begin
                stall_cnt <= '0;
            end

`ifdef COM_LOADER_CHECKSUM_EN
            if (ck_fail)
                err_q <= 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[load_count[IW-1:0]] <= word_in;
        if ({1'b0, rd_addr} < WORDS_V)
            rd_data <= mem[rd_addr[IW-1:0]];
    end

    assign io.rx_ready         = rx_ready;
    assign io.com_data_in      = data_o;
    assign io.data_write_start = start_o;
    assign io.data_write_done  = done_o;
    assign io.busy             = busy_o;
    assign io.load_count       = load_count;
    assign io.err              = err_q;
endmodule

// File: tb/tb_com_stream_loader.sv
// Bench for com_stream_loader: a WORDS=4 instance for cycle-level checks and a
// WORDS=1024 instance for back-to-back full-size blocks. Expected burst words
// are queued when a block is driven and popped as the burst appears.
// Honours COM_LOADER_CHECKSUM_EN by appending trailer words.
module tb_com_stream_loader;
    localparam int W   = 4;
    localparam int AWS = 3;
    localparam int WB  = 1024;
    localparam int AWB = 10;
`ifdef COM_LOADER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam int NB = 2 * W + 2 * CK;
    localparam int NV = NB + W + 4;

    localparam logic [W-1:0][15:0] WS1 = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    localparam logic [W-1:0][15:0] WS2 = {16'h0044, 16'h0033, 16'h0022, 16'h5AAA};
    localparam logic [W-1:0][15:0] WS3 = {16'hC0DE, 16'h8001, 16'h7FFF, 16'hFFFF};
    localparam logic [W-1:0][15:0] WS4 = {16'h0F0F, 16'hA5A5, 16'h5678, 16'h1234};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    com_stream_loader_if #(.AW(AWS)) si ();
    com_stream_loader_if #(.AW(AWB)) bi ();

    com_stream_loader #(.WORDS(W), .AW(AWS)) dut (
        .clk (clk),
        .rst (rst),
        .io  (si)
    );

    com_stream_loader #(.WORDS(WB), .AW(AWB)) dut_big (
        .clk (clk),
        .rst (rst),
        .io  (bi)
    );

    int checks = 0;
    int errors = 0;
    bit abort  = 1'b0;

    logic [15:0] sb [$];
    int ph      = -1;
    int n_start = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Small-instance burst monitor: framing, zero pad, queued words, done timing.
    always @(negedge clk) begin
        logic [15:0] exp_w;
        if (rst) begin
            ph = -1;
            sb.delete();
        end else if (ph < 0) begin
            if (si.data_write_start) begin
                n_start++;
                chk("start_data", si.com_data_in, 0);
                chk("start_queued", sb.size() >= W, 1);
                ph = 1;
            end else begin
                chk("idle_out", {si.data_write_done, si.com_data_in}, 0);
            end
        end else if (ph == 1) begin
            chk("pad_out", {si.data_write_start, si.com_data_in}, 0);
            ph = 2;
        end else if (ph <= W + 1) begin
            exp_w = (sb.size() != 0) ? sb.pop_front() : 16'hDEAD;
            chk("burst_word", si.com_data_in, exp_w);
            chk("burst_done", si.data_write_done, (ph == W + 1) ? 1 : 0);
            ph++;
        end else begin
            chk("done_cycle", {si.data_write_done, si.com_data_in, si.busy, si.rx_ready}, 18'h2);
            ph = -1;
        end
    end

    // Large-instance monitor: contiguous 1024-word bursts and the refill gap.
    int bph = -1;
    int bblk = 0;
    int bytes_since_done = -1;
    always @(negedge clk) begin
        if (!rst) begin
            if (bi.rx_valid && bi.rx_ready && bytes_since_done >= 0)
                bytes_since_done++;
            if (bph < 0) begin
                if (bi.data_write_start) begin
                    if (bblk == 1)
                        chk("big_gap_bytes", (bytes_since_done >= 2 * WB + 2 * CK) ? 1 : 0, 1);
                    bph = 1;
                end
            end else if (bph == 1) begin
                chk("big_pad", bi.com_data_in, 0);
                bph = 2;
            end else if (bph <= WB + 1) begin
                chk("big_word", bi.com_data_in, 32'(16'((bph - 2) + bblk * 32'h8000)));
                chk("big_done", bi.data_write_done, (bph == WB + 1) ? 1 : 0);
                bph++;
            end else begin
                bytes_since_done = 0;
                bblk++;
                bph = -1;
            end
        end
    end

    task automatic send_s(input logic [7:0] v);
        int n = 0;
        if (abort) return;
        si.rx_byte  = v;
        si.rx_valid = 1'b1;
        @(negedge clk);
        while (!si.rx_ready) begin
            n++;
            if (n > 2 * W + 20) begin
                checks++;
                errors++;
                $display("FAIL rx_ready_timeout: byte %h waited %0d cycles, limit %0d", v, n, 2 * W + 20);
                abort = 1'b1;
                si.rx_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_b(input logic [7:0] v);
        int n = 0;
        if (abort) return;
        bi.rx_byte  = v;
        bi.rx_valid = 1'b1;
        @(negedge clk);
        while (!bi.rx_ready) begin
            n++;
            if (n > 2 * WB + 20) begin
                checks++;
                errors++;
                $display("FAIL big_ready_timeout: byte %h waited %0d cycles, limit %0d", v, n, 2 * WB + 20);
                abort = 1'b1;
                bi.rx_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    // Drives one block; pre_lo means word 0's low byte was already accepted.
    task automatic send_block_s(input logic [W-1:0][15:0] ws, input bit bad, input bit pre_lo);
        logic [15:0] sum = 16'h0000;
        if (!bad)
            for (int k = 0; k < W; k++) sb.push_back(ws[k]);
        for (int k = 0; k < W; k++) begin
            if (!(k == 0 && pre_lo)) send_s(ws[k][7:0]);
            send_s(ws[k][15:8]);
            sum = sum + ws[k];
        end
        if (CK != 0) begin
            if (bad) sum = sum + 16'h0001;
            send_s(sum[7:0]);
            send_s(sum[15:8]);
        end
        si.rx_valid = 1'b0;
    endtask

    task automatic drain_s();
        int n = 0;
        while ((sb.size() != 0 || ph >= 0) && n < 4 * W + 30) begin
            @(negedge clk);
            n++;
        end
        chk("drain", (sb.size() == 0 && ph < 0) ? 1 : 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_s(input string tag);
        chk({tag, "_ready"}, si.rx_ready, 1);
        chk({tag, "_start"}, si.data_write_start, 0);
        chk({tag, "_done"},  si.data_write_done, 0);
        chk({tag, "_data"},  si.com_data_in, 0);
        chk({tag, "_busy"},  si.busy, 0);
        chk({tag, "_lc"},    si.load_count, 0);
        chk({tag, "_err"},   si.err, 0);
    endtask

    typedef struct {
        logic        v;
        logic [7:0]  b8;
        logic        rdy;
        logic        st;
        logic        dn;
        logic [15:0] data;
        logic        bsy;
        logic [AWS:0] lc;
    } vec_t;

    vec_t tbl [NV];

    initial begin : watchdog
        #600000;
        $display("FAIL global_timeout: simulation exceeded 60000 cycles");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [W-1:0][15:0] ws;
        logic [15:0] w;
        logic [15:0] bsum;
        logic [23:0] act;
        logic [23:0] exp;
        int n;
        int found;
        int st0;

        si.rx_valid = 1'b0;
        si.rx_byte  = '0;
        bi.rx_valid = 1'b0;
        bi.rx_byte  = '0;
        rst = 1'b1;

        // Scenario 1 as a cycle table: byte feed, START, PAD, W words, DONE, FILL.
        ws = WS1;
        for (int i = 0; i < NV; i++) begin
            tbl[i] = '{v: 1'b0, b8: 8'h00, rdy: 1'b0, st: 1'b0, dn: 1'b0,
                       data: 16'h0000, bsy: 1'b1, lc: (AWS + 1)'(W)};
            if (i < NB) begin
                tbl[i].v   = 1'b1;
                tbl[i].rdy = 1'b1;
                tbl[i].bsy = 1'b0;
                tbl[i].lc  = (AWS + 1)'((i / 2 < W) ? i / 2 : W);
                if (i / 2 < W)
                    tbl[i].b8 = (i % 2 == 0) ? ws[i / 2][7:0] : ws[i / 2][15:8];
                else
                    tbl[i].b8 = (i % 2 == 0) ? 8'(W * (W + 1) / 2) : 8'h00;
            end else if (i == NB) begin
                tbl[i].st = 1'b1;
            end else if (i >= NB + 2 && i <= NB + W + 1) begin
                tbl[i].data = ws[i - NB - 2];
                tbl[i].dn   = (i == NB + W + 1);
            end else if (i == NB + W + 3) begin
                tbl[i].rdy = 1'b1;
                tbl[i].bsy = 1'b0;
                tbl[i].lc  = '0;
            end
        end

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_s("rst");
        chk("big_rst_ready", bi.rx_ready, 1);
        chk("big_rst_lc", bi.load_count, 0);
        @(posedge clk);
        #1;

        for (int k = 0; k < W; k++) sb.push_back(ws[k]);
        for (int i = 0; i < NV; i++) begin
            si.rx_valid = tbl[i].v;
            si.rx_byte  = tbl[i].b8;
            @(negedge clk);
            act = {si.rx_ready, si.data_write_start, si.data_write_done,
                   si.com_data_in, si.busy, si.load_count};
            exp = {tbl[i].rdy, tbl[i].st, tbl[i].dn, tbl[i].data, tbl[i].bsy, tbl[i].lc};
            chk($sformatf("vec%0d", i), 32'(act), 32'(exp));
            @(posedge clk);
            #1;
        end
        si.rx_valid = 1'b0;

        // Scenario 2: AA held through the burst lands as word 0's low byte.
        send_block_s(WS1, 1'b0, 1'b0);
        send_s(8'hAA);
        si.rx_valid = 1'b0;
        @(negedge clk);
        chk("held_lc", si.load_count, 0);
        chk("held_busy", si.busy, 0);
        @(posedge clk);
        #1;
        send_block_s(WS2, 1'b0, 1'b1);
        drain_s();
        chk("held_err", si.err, 0);

        // Scenario 4: valid every other cycle, plus a long-dangling first low byte.
        ws = WS1;
        for (int k = 0; k < W; k++) sb.push_back(ws[k]);
        for (int i = 0; i < NB; i++) begin
            send_s(tbl[i].b8);
            si.rx_valid = 1'b0;
            if (i == 0) repeat (12) @(posedge clk);
            @(negedge clk);
            chk($sformatf("toggle_lc%0d", i), si.load_count,
                ((i + 1) / 2 < W) ? (i + 1) / 2 : W);
            @(posedge clk);
            #1;
        end
        drain_s();

        // Scenario 3: reset in S+3 aborts the burst; next block starts clean.
        send_block_s(WS3, 1'b0, 1'b0);
        found = 0;
        n = 0;
        while (n < 4 * W + 20 && found == 0) begin
            @(negedge clk);
            if (si.data_write_start) found = 1;
            n++;
        end
        chk("rst_saw_start", found, 1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_s("midrst");
        @(posedge clk);
        #1;
        send_block_s(WS4, 1'b0, 1'b0);
        drain_s();

`ifdef COM_LOADER_CHECKSUM_EN
        // Bad trailer: no burst, err set, back in FILL; a good block still works after.
        st0 = n_start;
        send_block_s(WS1, 1'b1, 1'b0);
        repeat (W + 8) @(negedge clk);
        chk("ck_no_start", n_start, st0);
        chk("ck_err", si.err, 1);
        chk("ck_busy", si.busy, 0);
        chk("ck_ready", si.rx_ready, 1);
        chk("ck_lc", si.load_count, 0);
        @(posedge clk);
        #1;
        send_block_s(WS1, 1'b0, 1'b0);
        drain_s();
`else
        st0 = 0;
`endif

        // Scenario 6: two full-size blocks back to back.
        for (int blk = 0; blk < 2; blk++) begin
            bsum = 16'h0000;
            for (int k = 0; k < WB; k++) begin
                w = 16'(k + blk * 32'h8000);
                send_b(w[7:0]);
                send_b(w[15:8]);
                bsum = bsum + w;
            end
            if (CK != 0) begin
                send_b(bsum[7:0]);
                send_b(bsum[15:8]);
            end
        end
        bi.rx_valid = 1'b0;
        n = 0;
        while (bblk < 2 && n < 3 * WB) begin
            @(negedge clk);
            n++;
        end
        chk("big_bursts", bblk, 2);
        chk("big_err", bi.err, 0);
        chk("err_final", si.err, CK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
